// File: rtl/vga_sync_generator.sv
// vga_sync_generator: VGA raster counters, line/frame strobes and sync/active outputs delayed to match pixel latency
module vga_sync_generator #(
   parameter int   c_VISIBLE_COLUMNS   = 640,
   parameter int   c_VISIBLE_ROWS      = 480,
   parameter int   c_TOTAL_COLUMNS     = 800,
   parameter int   c_TOTAL_ROWS        = 525,
   parameter int   c_H_FRONT_PORCH     = 16,
   parameter int   c_H_SYNC_WIDTH      = 96,
   parameter int   c_V_FRONT_PORCH     = 10,
   parameter int   c_V_SYNC_WIDTH      = 2,
   parameter logic c_SYNC_ACTIVE_LEVEL = 1'b0,
   parameter int   c_VIDEO_DELAY       = 2
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   output logic [9:0] o_ColCount,
   output logic [9:0] o_RowCount,
   output logic       o_HSync,
   output logic       o_VSync,
   output logic       o_ActiveVideo,
   output logic       o_FrameStart,
   output logic       o_LineStart
);
   localparam logic [9:0] c_COL_LAST = 10'(c_TOTAL_COLUMNS - 1);
   localparam logic [9:0] c_ROW_LAST = 10'(c_TOTAL_ROWS - 1);
   localparam logic [9:0] c_VIS_COLS = 10'(c_VISIBLE_COLUMNS);
   localparam logic [9:0] c_VIS_ROWS = 10'(c_VISIBLE_ROWS);
   localparam logic [9:0] c_H_FIRST  = 10'(c_VISIBLE_COLUMNS + c_H_FRONT_PORCH);
   localparam logic [9:0] c_H_LAST   = 10'(c_VISIBLE_COLUMNS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH - 1);
   localparam logic [9:0] c_V_FIRST  = 10'(c_VISIBLE_ROWS + c_V_FRONT_PORCH);
   localparam logic [9:0] c_V_LAST   = 10'(c_VISIBLE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH - 1);
   localparam logic       c_INACTIVE = ~c_SYNC_ACTIVE_LEVEL;
   localparam logic [2:0] c_IDLE     = {c_INACTIVE, c_INACTIVE, 1'b0};

   logic [9:0] col_q, col_d, row_q, row_d;
   logic       line_start_q, line_start_d, frame_start_q, frame_start_d;
   logic [2:0] video_raw;

   always_comb begin
      col_d         = (col_q == c_COL_LAST) ? '0 : col_q + 10'd1;
      row_d         = (col_q != c_COL_LAST) ? row_q : (row_q == c_ROW_LAST) ? '0 : row_q + 10'd1;
      line_start_d  = (col_d == '0);
      frame_start_d = line_start_d && (row_d == '0);
      video_raw     = {(col_q >= c_H_FIRST && col_q <= c_H_LAST) ? c_SYNC_ACTIVE_LEVEL : c_INACTIVE,
                       (row_q >= c_V_FIRST && row_q <= c_V_LAST) ? c_SYNC_ACTIVE_LEVEL : c_INACTIVE,
                       i_Rst_n && (col_q < c_VIS_COLS) && (row_q < c_VIS_ROWS)};
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n)
      if (!i_Rst_n) begin
         col_q         <= '0;
         row_q         <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         col_q         <= col_d;
         row_q         <= row_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end

   assign o_ColCount   = col_q;
   assign o_RowCount   = row_q;
   assign o_LineStart  = line_start_q;
   assign o_FrameStart = frame_start_q;

   generate
      if (c_VIDEO_DELAY == 0) begin : g_no_delay
         assign {o_HSync, o_VSync, o_ActiveVideo} = video_raw;
      end else begin : g_delay
         logic [2:0] pipe_q [c_VIDEO_DELAY];
         logic [2:0] pipe_d [c_VIDEO_DELAY];
         always_comb begin
            pipe_d[0] = video_raw;
            for (int i = 1; i < c_VIDEO_DELAY; i++) pipe_d[i] = pipe_q[i-1];
         end
         always_ff @(posedge i_Clk or negedge i_Rst_n)
            if (!i_Rst_n) begin
               for (int i = 0; i < c_VIDEO_DELAY; i++) pipe_q[i] <= c_IDLE;
            end else begin
               for (int i = 0; i < c_VIDEO_DELAY; i++) pipe_q[i] <= pipe_d[i];
            end
         assign {o_HSync, o_VSync, o_ActiveVideo} = pipe_q[c_VIDEO_DELAY-1];
      end
   endgenerate
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: directed checks of default, small-raster and zero-delay/active-high configurations
module tb_vga_sync_generator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   n = 0;

   logic [9:0] d_col, d_row, s_col, s_row, p_col, p_row;
   logic       d_hs, d_vs, d_av, d_fs, d_ls;
   logic       s_hs, s_vs, s_av, s_fs, s_ls;
   logic       p_hs, p_vs, p_av, p_fs, p_ls;

   always #5 clk = ~clk;

   vga_sync_generator u_dflt (
      .i_Clk(clk), .i_Rst_n(rst_n), .o_ColCount(d_col), .o_RowCount(d_row),
      .o_HSync(d_hs), .o_VSync(d_vs), .o_ActiveVideo(d_av), .o_FrameStart(d_fs), .o_LineStart(d_ls));

   // 32x16 raster, syncs at cols 24..29 and rows 12..13, three-stage delay
   vga_sync_generator #(
      .c_VISIBLE_COLUMNS(20), .c_VISIBLE_ROWS(10), .c_TOTAL_COLUMNS(32), .c_TOTAL_ROWS(16),
      .c_H_FRONT_PORCH(4), .c_H_SYNC_WIDTH(6), .c_V_FRONT_PORCH(2), .c_V_SYNC_WIDTH(2),
      .c_SYNC_ACTIVE_LEVEL(1'b0), .c_VIDEO_DELAY(3)
   ) u_small (
      .i_Clk(clk), .i_Rst_n(rst_n), .o_ColCount(s_col), .o_RowCount(s_row),
      .o_HSync(s_hs), .o_VSync(s_vs), .o_ActiveVideo(s_av), .o_FrameStart(s_fs), .o_LineStart(s_ls));

   vga_sync_generator #(.c_SYNC_ACTIVE_LEVEL(1'b1), .c_VIDEO_DELAY(0)) u_pol (
      .i_Clk(clk), .i_Rst_n(rst_n), .o_ColCount(p_col), .o_RowCount(p_row),
      .o_HSync(p_hs), .o_VSync(p_vs), .o_ActiveVideo(p_av), .o_FrameStart(p_fs), .o_LineStart(p_ls));

   task automatic step;
      @(negedge clk);
      n++;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({d_col, d_row} !== 20'd0) begin errors++; $display("FAIL rst_count got %0d,%0d exp 0,0", d_col, d_row); end
      checks++; if ({d_hs, d_vs, d_av, d_fs, d_ls} !== 5'b11000) begin errors++; $display("FAIL rst_outs got %b exp 11000", {d_hs, d_vs, d_av, d_fs, d_ls}); end
      checks++; if ({p_hs, p_vs, p_av, p_fs, p_ls} !== 5'b00000) begin errors++; $display("FAIL rst_pol_outs got %b exp 00000", {p_hs, p_vs, p_av, p_fs, p_ls}); end
      checks++; if ({s_col, s_row, s_hs, s_vs, s_av} !== {20'd0, 3'b110}) begin errors++; $display("FAIL rst_small got %0d,%0d %b exp 0,0 110", s_col, s_row, {s_hs, s_vs, s_av}); end
      rst_n = 1'b1;
      n = 0;
      step();
      checks++; if ({d_col, d_row} !== {10'd1, 10'd0}) begin errors++; $display("FAIL rel_count got %0d,%0d exp 1,0", d_col, d_row); end
      checks++; if ({d_hs, d_vs, d_av, d_fs, d_ls} !== 5'b11000) begin errors++; $display("FAIL rel_fill1 got %b exp 11000", {d_hs, d_vs, d_av, d_fs, d_ls}); end
      checks++; if ({p_hs, p_av, s_col} !== {2'b01, 10'd1}) begin errors++; $display("FAIL rel_other got %b col %0d exp 01 col 1", {p_hs, p_av}, s_col); end
      step();
      checks++; if ({d_col, d_hs, d_vs, d_av} !== {10'd2, 3'b111}) begin errors++; $display("FAIL rel_fill2 got col %0d %b exp col 2 111", d_col, {d_hs, d_vs, d_av}); end
      checks++; if (s_av !== 1'b0) begin errors++; $display("FAIL rel_small_fill got %b exp 0", s_av); end
      step();
      checks++; if (s_av !== 1'b1) begin errors++; $display("FAIL rel_small_av got %b exp 1", s_av); end
   endtask

   task automatic test_h_sweep;
      int hs_low = 0;
      int av_high = 0;
      int first_low = -1;
      int last_low = -1;
      logic [9:0] ec, er;
      logic eh, ea, ep;
      for (int k = 0; k < 1600; k++) begin
         step();
         ec = 10'(n % 800);
         er = 10'(n / 800);
         eh = !(((n - 2) % 800) >= 656 && ((n - 2) % 800) <= 751);
         ea = ((n - 2) % 800) < 640;
         ep = (n % 800) >= 656 && (n % 800) <= 751;
         checks++; if ({d_col, d_row} !== {ec, er}) begin errors++; $display("FAIL h_count n=%0d got %0d,%0d exp %0d,%0d", n, d_col, d_row, ec, er); end
         checks++; if (d_hs !== eh) begin errors++; $display("FAIL h_hsync n=%0d got %b exp %b", n, d_hs, eh); end
         checks++; if (d_av !== ea) begin errors++; $display("FAIL h_active n=%0d got %b exp %b", n, d_av, ea); end
         checks++; if ({d_vs, d_fs, d_ls} !== {2'b10, ec == 10'd0}) begin errors++; $display("FAIL h_vs_strobe n=%0d got %b", n, {d_vs, d_fs, d_ls}); end
         checks++; if ({p_hs, p_av} !== {ep, ec < 10'd640}) begin errors++; $display("FAIL h_pol n=%0d got %b exp %b", n, {p_hs, p_av}, {ep, ec < 10'd640}); end
         checks++; if (s_fs !== (n % 512 == 0)) begin errors++; $display("FAIL h_small_fs n=%0d got %b", n, s_fs); end
         if (!d_hs) begin
            hs_low++;
            if (first_low < 0) first_low = int'(d_col);
            if (n < 800) last_low = int'(d_col);
         end
         if (d_av) av_high++;
      end
      checks++; if (hs_low != 192 || first_low != 658 || last_low != 753) begin errors++; $display("FAIL h_window got %0d low %0d..%0d exp 192 low 658..753", hs_low, first_low, last_low); end
      checks++; if (av_high != 1280) begin errors++; $display("FAIL h_active_count got %0d exp 1280", av_high); end
   endtask

   task automatic test_line_wrap;
      while (n != 800 * 10 + 799) step();
      checks++; if ({d_col, d_row} !== {10'd799, 10'd10}) begin errors++; $display("FAIL lw_pre got %0d,%0d exp 799,10", d_col, d_row); end
      step();
      checks++; if ({d_col, d_row, d_ls, d_fs} !== {10'd0, 10'd11, 2'b10}) begin errors++; $display("FAIL lw_wrap got %0d,%0d ls%b fs%b exp 0,11 ls1 fs0", d_col, d_row, d_ls, d_fs); end
      step();
      checks++; if ({d_col, d_ls} !== {10'd1, 1'b0}) begin errors++; $display("FAIL lw_post got col %0d ls%b exp col 1 ls0", d_col, d_ls); end
   endtask

   task automatic test_v_sweep;
      int vs_low = 0;
      int first_low = -1;
      int sm, smc, smr;
      logic ev, eh, ea;
      while (n % 512 != 511) step();
      checks++; if ({s_col, s_row} !== {10'd31, 10'd15}) begin errors++; $display("FAIL fw_pre got %0d,%0d exp 31,15", s_col, s_row); end
      step();
      checks++; if ({s_col, s_row, s_fs, s_ls} !== {20'd0, 2'b11}) begin errors++; $display("FAIL fw_wrap got %0d,%0d fs%b ls%b exp 0,0 fs1 ls1", s_col, s_row, s_fs, s_ls); end
      for (int k = 0; k < 512; k++) begin
         step();
         sm  = n - 3;
         smc = sm % 32;
         smr = (sm % 512) / 32;
         ev  = !(smr >= 12 && smr <= 13);
         eh  = !(smc >= 24 && smc <= 29);
         ea  = smc < 20 && smr < 10;
         checks++; if ({s_col, s_row} !== {10'(n % 32), 10'((n % 512) / 32)}) begin errors++; $display("FAIL v_count n=%0d got %0d,%0d", n, s_col, s_row); end
         checks++; if ({s_vs, s_hs, s_av} !== {ev, eh, ea}) begin errors++; $display("FAIL v_video n=%0d got %b exp %b", n, {s_vs, s_hs, s_av}, {ev, eh, ea}); end
         checks++; if ({s_fs, s_ls, d_fs} !== {n % 512 == 0, n % 32 == 0, 1'b0}) begin errors++; $display("FAIL v_strobe n=%0d got %b", n, {s_fs, s_ls, d_fs}); end
         if (!s_vs) begin
            vs_low++;
            if (first_low < 0) first_low = int'(s_row) * 32 + int'(s_col);
         end
      end
      checks++; if (vs_low != 64 || first_low != 12 * 32 + 3) begin errors++; $display("FAIL v_window got %0d low from %0d exp 64 from %0d", vs_low, first_low, 12 * 32 + 3); end
   endtask

   task automatic test_mid_reset;
      while (n % 512 != 8 * 32 + 20) step();
      checks++; if ({s_row, s_col, s_av} !== {10'd8, 10'd20, 1'b1}) begin errors++; $display("FAIL mr_pre got %0d,%0d av%b exp 8,20 av1", s_row, s_col, s_av); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({s_col, s_row, s_hs, s_vs, s_av, s_fs, s_ls} !== {20'd0, 5'b11000}) begin errors++; $display("FAIL mr_small got %0d,%0d %b", s_col, s_row, {s_hs, s_vs, s_av, s_fs, s_ls}); end
      checks++; if ({d_col, d_row, d_hs, d_vs, d_av} !== {20'd0, 3'b110}) begin errors++; $display("FAIL mr_dflt got %0d,%0d %b", d_col, d_row, {d_hs, d_vs, d_av}); end
      checks++; if ({p_hs, p_vs, p_av} !== 3'b000) begin errors++; $display("FAIL mr_pol got %b exp 000", {p_hs, p_vs, p_av}); end
      @(negedge clk);
      checks++; if ({d_col, s_col} !== 20'd0) begin errors++; $display("FAIL mr_hold got %0d,%0d exp 0,0", d_col, s_col); end
      rst_n = 1'b1;
      n = 0;
      step();
      checks++; if ({s_col, s_row, d_col, d_row} !== {10'd1, 10'd0, 10'd1, 10'd0}) begin errors++; $display("FAIL mr_restart got s %0d,%0d d %0d,%0d exp 1,0", s_col, s_row, d_col, d_row); end
      checks++; if ({s_hs, s_av, d_fs, s_fs} !== 4'b1000) begin errors++; $display("FAIL mr_restart_outs got %b exp 1000", {s_hs, s_av, d_fs, s_fs}); end
   endtask

   task automatic test_param;
      int hs_high = 0;
      logic eh;
      for (int k = 0; k < 800; k++) begin
         step();
         eh = (n % 800) >= 656 && (n % 800) <= 751;
         checks++; if ({p_hs, p_vs, p_av} !== {eh, 1'b0, (n % 800) < 640}) begin errors++; $display("FAIL p_video n=%0d col %0d got %b", n, p_col, {p_hs, p_vs, p_av}); end
         checks++; if (p_col !== 10'(n % 800)) begin errors++; $display("FAIL p_col n=%0d got %0d exp %0d", n, p_col, n % 800); end
         if (p_hs) hs_high++;
      end
      checks++; if (hs_high != 96) begin errors++; $display("FAIL p_width got %0d exp 96", hs_high); end
   endtask

   initial begin
      test_reset();
      test_h_sweep();
      test_line_wrap();
      test_v_sweep();
      test_mid_reset();
      test_param();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
